// File: rtl/adder_pkg.sv
// adder_pkg: flag layout, flag type and configuration check shared by pipelined_adder and its segments
package adder_pkg;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef logic [3:0] flags_t;
    function automatic bit legal_cfg(int width, int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: one registered SEG-bit slice of the carry chain with its carry-out and zero bit
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [SEG-1:0] a_s,
    input  logic [SEG-1:0] b_s,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           zero
);
    logic [SEG:0] sum_d;
    logic [SEG:0] sum_q;
    logic         zero_q;
    assign sum_d = {1'b0, a_s} + {1'b0, b_s} + {{SEG{1'b0}}, cin};
    // Capture the slice sum with its carry-out and whether the slice came out all zero
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            zero_q <= 1'b0;
        end else if (enable) begin
            sum_q  <= sum_d;
            zero_q <= (sum_d[SEG-1:0] == '0);
        end
    end
    assign s    = sum_q[SEG-1:0];
    assign cout = sum_q[SEG];
    assign zero = zero_q;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep add/subtract with valid/ready handshake and NZCV flags; PIPELINED_ADDER_SAT_EN adds saturation
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output flags_t           flags
);
    localparam int SEG = WIDTH / STAGES;
    if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end
    // Index j is the boundary feeding stage j; index STAGES is the final-stage output
    logic [STAGES:0][WIDTH-1:0]  a_d, b_d, s_d;
    logic [STAGES:0][STAGES-1:0] z_d;
    logic [STAGES:0]             c_d, v_d, sat_d;
    logic                        stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = reset || !stall;
    assign a_d[0]   = a;
    assign b_d[0]   = sub ? ~b : b;
    assign c_d[0]   = sub;
    assign s_d[0]   = '0;
    assign z_d[0]   = '0;
    assign v_d[0]   = in_valid;
`ifdef PIPELINED_ADDER_SAT_EN
    assign sat_d[0] = sat;
`else
    assign sat_d[0] = 1'b0;
`endif
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]    seg_s;
        logic              seg_c, seg_z, vld_q, sat_q;
        logic [WIDTH-1:0]  a_q, b_q, s_q;
        logic [STAGES-1:0] z_q;
        adder_segment #(.SEG(SEG)) u_seg (
            .clk   (clk),
            .reset (reset),
            .enable(!stall),
            .a_s   (a_d[k][k*SEG +: SEG]),
            .b_s   (b_d[k][k*SEG +: SEG]),
            .cin   (c_d[k]),
            .s     (seg_s),
            .cout  (seg_c),
            .zero  (seg_z)
        );
        // Skew operands toward later segments and deskew finished lower slices beside this segment
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= 1'b0;
                sat_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                z_q   <= '0;
            end else if (!stall) begin
                vld_q <= v_d[k];
                sat_q <= sat_d[k];
                a_q   <= a_d[k];
                b_q   <= b_d[k];
                s_q   <= s_d[k];
                z_q   <= z_d[k];
            end
        end
        assign v_d[k+1]   = vld_q;
        assign sat_d[k+1] = sat_q;
        assign a_d[k+1]   = a_q;
        assign b_d[k+1]   = b_q;
        assign c_d[k+1]   = seg_c;
        assign s_d[k+1]   = s_q | (WIDTH'(seg_s) << (k * SEG));
        assign z_d[k+1]   = z_q | (STAGES'(seg_z) << k);
    end
    logic [WIDTH-1:0] raw, lim;
    logic             a_msb, ovf, clamp;
    logic             unused_ok;
    assign unused_ok = ^{a_d[STAGES], b_d[STAGES]};
    assign out_valid = v_d[STAGES];
    assign raw       = s_d[STAGES];
    assign a_msb     = a_d[STAGES][WIDTH-1];
    assign ovf       = (a_msb == b_d[STAGES][WIDTH-1]) && (raw[WIDTH-1] != a_msb);
    assign clamp     = sat_d[STAGES] && ovf;
    assign lim       = {a_msb, {(WIDTH-1){!a_msb}}};
    assign sum       = clamp ? lim : raw;
    // N, C and V describe the wrapped result; Z follows the value actually presented on sum
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = raw[WIDTH-1];
        flags[FLAG_Z] = &z_d[STAGES] && !clamp;
        flags[FLAG_C] = c_d[STAGES];
        flags[FLAG_V] = ovf;
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed scoreboard bench for pipelined_adder (WIDTH=64, STAGES=4)
module tb_pipelined_adder;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic signed [65:0] SMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -66'sh8000_0000_0000_0000;
    typedef struct packed {
        logic [63:0] s;
        logic [3:0]  f;
    } exp_t;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, sub = 1'b0, sat = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [63:0] a = '0, b = '0, sum;
    logic [3:0]  flags;
    exp_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0, n_out = 0;
    always #5 clk = ~clk;
    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
`ifdef PIPELINED_ADDER_SAT_EN
        .sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .flags    (flags)
    );
    // Reference: exact signed/unsigned integer arithmetic, flags from their definitions
    function automatic exp_t model(logic [63:0] x, logic [63:0] y, logic s, logic st);
        logic signed [65:0] sx, sy, r;
        logic [64:0]        u;
        logic               c, v;
        exp_t               e;
        sx = $signed({{2{x[63]}}, x});
        sy = $signed({{2{y[63]}}, y});
        r  = s ? sx - sy : sx + sy;
        u  = {1'b0, x} + {1'b0, y};
        c  = s ? (x >= y) : u[64];
        v  = (r > SMAX) || (r < SMIN);
        e.s = r[63:0];
        e.f = {e.s[63], 1'b0, c, v};
        if (st && v) e.s = r[65] ? {1'b1, 63'b0} : {1'b0, {63{1'b1}}};
        e.f[2] = (e.s == 64'd0);
        return e;
    endfunction
    function automatic logic [63:0] pick();
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? 64'd0 : k == 1 ? '1 : k == 2 ? 64'h7FFF_FFFF_FFFF_FFFF :
               k == 3 ? 64'h8000_0000_0000_0000 : k == 4 ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
    endfunction
    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask
    // Called at a negedge; holds the operands until accepted, then returns at the next negedge
    task automatic send(logic [63:0] x, logic [63:0] y, logic s, logic st);
        int tries = 0;
        a = x; b = y; sub = s; sat = st; in_valid = 1'b1;
        #1;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            #1;
            tries++;
        end
        chk("accept", in_ready, 1);
        if (in_ready) exp_q.push_back(model(x, y, s, SAT_EN && st));
        @(negedge clk);
    endtask
    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask
    task automatic latency_op(logic [63:0] x, logic [63:0] y, logic s);
        int lat = 1;
        send(x, y, s, 1'b0);
        in_valid = 1'b0;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, STAGES);
        @(negedge clk);
    endtask
    // Monitor: pops and compares on every transfer, and checks stall behaviour
    initial begin
        logic        held = 1'b0;
        logic [63:0] h_sum = '0;
        logic [3:0]  h_flags = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) held = 1'b0;
            else begin
                if (held) begin
                    chk("stall_hold_sum", sum, h_sum);
                    chk("stall_hold_flags", flags, h_flags);
                end
                held = out_valid && !out_ready;
                if (held) begin
                    chk("stall_in_ready", in_ready, 0);
                    h_sum = sum;
                    h_flags = flags;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got sum %h, expected no result", sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", sum, e.s);
                        chk("flags", flags, e.f);
                    end
                    n_out++;
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int base;
        @(negedge clk);
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        latency_op(64'd1, 64'd1, 1'b0);
        send('1, 64'd1, 1'b0, 1'b0);
        send(64'd5, 64'd7, 1'b1, 1'b0);
        send(64'd7, 64'd5, 1'b1, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
        send(64'd9, 64'd0, 1'b1, 1'b0);
        drain();
        base = n_out;
        fork
            for (int i = 0; i < 8; i++) send(64'(i), 64'd100, 1'b0, 1'b0);
            begin
                int t = 0;
                while (n_out < base + 2 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                out_ready = 1'b0;
                #2;
                chk("stall_seen", out_valid, 1);
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_out - base, 8);
        send(64'd11, 64'd22, 1'b0, 1'b0);
        send(64'd33, 64'd44, 1'b1, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        #2;
        chk("rst_in_ready_flush", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_sum", sum, 0);
        chk("flush_flags", flags, 0);
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("flush_no_emit", out_valid, 0);
        end
        @(negedge clk);
        latency_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a   = pick();
            b   = pick();
            sub = 1'($urandom_range(0, 1));
            sat = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, SAT_EN && sat));
        end
        @(negedge clk);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
